// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop rxd synchroniser; with UART_RX_MAJORITY_EN defined, rx_bit is a 3-tick majority vote
// ending at the current clk_en tick, otherwise rx_bit is the synchronised line itself.
module uart_rx_sampler (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic rxd,
    output logic rxd_s,
    output logic rx_bit
);

    logic sync1;

    // Idle-high reset so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 2'b11;
        end else if (clk_en) begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign rx_bit = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
    logic unused_clk_en;
    assign unused_clk_en = clk_en;
    assign rx_bit        = rxd_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (parity, 1/2 stop, break) feeding an AXI-Stream sink.
// Optional majority-vote sampling is enabled with the UART_RX_MAJORITY_EN macro.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  rxd,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  break_detect
);

    localparam int OS = (OVERSAMPLE < MIN_OVERSAMPLE) ? MIN_OVERSAMPLE : OVERSAMPLE;
    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    rx_state_t             state, state_nxt;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_buf;
    logic [1:0]            par_cfg;
    logic                  stop2_cfg;
    logic                  parity_ok, zero_acc, stop_idx, stop_bad, brk_first;
    logic                  rxd_s, rx_bit;
    logic                  sample, last_stop, stop_fail, brk_now, par_on;

    uart_rx_sampler u_sampler (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .rxd    (rxd),
        .rxd_s  (rxd_s),
        .rx_bit (rx_bit)
    );

    assign par_on = (par_cfg == PAR_EVEN) || (par_cfg == PAR_ODD);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sample    = clk_en && (tick_cnt == ((state == START) ? TICK_HALF : TICK_FULL));
        last_stop = !stop2_cfg || stop_idx;
        stop_fail = stop_bad || !rx_bit;
        // Break needs the first stop sample low; with two stops that sample was taken earlier.
        brk_now   = stop_idx ? brk_first : (zero_acc && !rx_bit);
        case (state)
            IDLE:      if (!rxd_s) state_nxt = START;
            START:     if (sample) state_nxt = rx_bit ? IDLE : DATA;
            DATA:      if (sample && bit_cnt == BIT_LAST) state_nxt = par_on ? PARITY : STOP;
            PARITY:    if (sample) state_nxt = STOP;
            STOP:      if (sample && last_stop) state_nxt = stop_fail ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (rxd_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        overrun_error <= 1'b0;
        frame_error   <= 1'b0;
        parity_error  <= 1'b0;
        break_detect  <= 1'b0;
        if (reset) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_buf     <= '0;
            par_cfg       <= PAR_NONE;
            stop2_cfg     <= 1'b0;
            parity_ok     <= 1'b0;
            zero_acc      <= 1'b0;
            stop_idx      <= 1'b0;
            stop_bad      <= 1'b0;
            brk_first     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            if (state != IDLE && state != WAIT_IDLE && clk_en)
                tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: if (!rxd_s) begin
                    tick_cnt  <= '0;
                    par_cfg   <= cfg_parity;
                    stop2_cfg <= cfg_stop2;
                end
                START: if (sample) begin
                    bit_cnt   <= '0;
                    zero_acc  <= 1'b1;
                    parity_ok <= 1'b1;
                end
                DATA: if (sample) begin
                    shift_buf <= {rx_bit, shift_buf[DATA_WIDTH-1:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                    zero_acc  <= zero_acc && !rx_bit;
                    stop_idx  <= 1'b0;
                    stop_bad  <= 1'b0;
                end
                PARITY: if (sample) begin
                    parity_ok <= (((^shift_buf) ^ rx_bit) == (par_cfg == PAR_ODD));
                    zero_acc  <= zero_acc && !rx_bit;
                end
                STOP: if (sample) begin
                    if (!last_stop) begin
                        stop_idx  <= 1'b1;
                        stop_bad  <= !rx_bit;
                        brk_first <= zero_acc && !rx_bit;
                    end else if (stop_fail) begin
                        frame_error  <= 1'b1;
                        break_detect <= brk_now;
                    end else if (!parity_ok) begin
                        parity_error <= 1'b1;
                    end else begin
                        m_axis_tdata  <= shift_buf;
                        m_axis_tvalid <= 1'b1;
                        overrun_error <= m_axis_tvalid && !m_axis_tready;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
